// File: rtl/mag_pkg.sv
// Shared types and helpers for the magnitude request arbiter.
package mag_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        RESULT = 2'd2
    } state_e;

    localparam int W_DEF   = 8;
    // Upper bound on the requester count that rr_pick can search.
    localparam int MAX_REQ = 32;

    // Round-robin winner: the first set bit of valid, searching from last+1
    // and wrapping modulo n. Returns last when nothing is valid, so callers
    // must qualify the result with |valid.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned       n,
                                            input int unsigned       last);
        int unsigned idx;
        int unsigned pick;
        pick = last;
        // Walk the offsets from far to near so the nearest valid requester wins.
        for (int unsigned k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mag_approx_core.sv
// Alpha-max-beta-min magnitude approximation: max + min/2 - 1, modulo 2^W.
module mag_approx_core
    import mag_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] mag
);

    logic [W-1:0] max_v;
    logic [W-1:0] min_v;

    // Order the operands and combine; the wrap at x=y=0 is intended.
    always_comb begin
        max_v = (x > y) ? x : y;
        min_v = (x > y) ? y : x;
        mag   = max_v + (min_v >> 1) - W'(1);
    end

endmodule

// File: rtl/mag_req_arbiter.sv
// Round-robin front end sharing one magnitude core between N_REQ requesters.
//
//  state  | meaning
//  IDLE   | pick a winner among valid requesters and accept its operands
//  CALC   | core evaluates latched operands; result registered on exit
//  RESULT | result held on res_* until res_ready
module mag_req_arbiter
    import mag_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = W_DEF,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [W-1:0]       res_data,
    output logic [IDW-1:0]     res_id,
    input  logic               res_ready,
    output logic               busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             busy_q, busy_d;

    logic [MAX_REQ-1:0] valid_ext;
    logic [IDW-1:0]     winner;
    logic               any_valid;
    logic [W-1:0]       x_sel;
    logic [W-1:0]       y_sel;
    logic [N_REQ-1:0]   ready_c;
    logic [W-1:0]       mag;

    mag_approx_core #(.W(W)) u_core (
        .x   (x_q),
        .y   (y_q),
        .mag (mag)
    );

    // Round-robin winner and its operands, muxed out of the packed buses.
    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = req_valid;
        any_valid              = |req_valid;
        winner = IDW'(rr_pick(valid_ext, N_REQ, 32'(last_grant_q)));
        x_sel  = '0;
        y_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == winner) begin
                x_sel = req_x[i*W +: W];
                y_sel = req_y[i*W +: W];
            end
        end
    end

    // Next-state, grant and result-register logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        ready_c      = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    // The grant always lands on a valid requester, so any
                    // valid input means a handshake this cycle.
                    ready_c      = N_REQ'(1) << winner;
                    x_d          = x_sel;
                    y_d          = y_sel;
                    id_d         = winner;
                    last_grant_d = winner;
                    state_d      = CALC;
                end
            end
            CALC: begin
                res_data_d  = mag;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d != IDLE);
        req_ready = rst ? '0 : ready_c;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(N_REQ - 1);
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            busy_q       <= busy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mag_req_arbiter.sv
// Randomized and directed bench for mag_req_arbiter against a cycle model.
module tb_mag_req_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N*W-1:0] req_y;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic [1:0]     res_id;
    logic           res_ready;
    logic           busy;

    mag_req_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stimulus to apply on the next cycle.
    logic        drv_rst;
    logic [3:0]  drv_v;
    logic        drv_rr;
    int unsigned xs[4];
    int unsigned ys[4];

    // Reference model: stage counts cycles since the grant (0 = free).
    int m_last;
    int m_stage;
    int m_x, m_y, m_id;
    int m_rv, m_rd, m_ri;

    int n_total = 0;
    int n_pass  = 0;
    int ids_q[$];
    logic [3:0] obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int pick(input logic [3:0] v);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int mag_ref(input int x, input int y);
        int mx, mn;
        mx = (x > y) ? x : y;
        mn = (x > y) ? y : x;
        return (mx + mn / 2 - 1 + 256) % 256;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_stage = 0;
        m_rv = 0; m_rd = 0; m_ri = 0;
        m_x = 0; m_y = 0; m_id = 0;
    endtask

    task automatic cycle();
        int w;
        logic [3:0] er;
        @(negedge clk);
        rst       = drv_rst;
        req_valid = drv_v;
        res_ready = drv_rr;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = 8'(xs[i]);
            req_y[i*W +: W] = 8'(ys[i]);
        end
        #1;
        w  = pick(drv_v);
        er = (drv_rst || m_stage != 0 || w < 0) ? 4'b0 : 4'(1 << w);
        obs_ready = req_ready;
        chk("req_ready", req_ready, er);
        if (res_valid && res_ready) ids_q.push_back(int'(res_id));
        @(posedge clk);
        if (drv_rst) begin
            model_reset();
        end else if (m_stage == 0) begin
            if (w >= 0) begin
                m_x = int'(xs[w] % 256); m_y = int'(ys[w] % 256); m_id = w;
                m_last = w; m_stage = 1;
            end
        end else if (m_stage == 1) begin
            m_rd = mag_ref(m_x, m_y); m_ri = m_id; m_rv = 1; m_stage = 2;
        end else if (drv_rr) begin
            m_rv = 0; m_stage = 0;
        end
        #1;
        chk("res_valid", res_valid, m_rv);
        chk("res_data", res_data, m_rd);
        chk("res_id", res_id, m_ri);
        chk("busy", busy, m_stage != 0);
    endtask

    task automatic run_op(input string tag, input int id, input int x, input int y,
                          input int exp);
        int n;
        drv_v = 4'(1 << id); xs[id] = x; ys[id] = y; drv_rr = 1'b0;
        cycle();
        drv_v = 4'b0;
        n = 0;
        while (!res_valid && n < 10) begin
            cycle();
            n++;
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_data"}, res_data, exp);
        chk({tag, "_id"}, res_id, id);
        drv_rr = 1'b1;
        cycle();
        drv_rr = 1'b0;
    endtask

    initial begin
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};
        model_reset();
        for (int i = 0; i < N; i++) begin xs[i] = 0; ys[i] = 0; end

        // Reset held two cycles with requests pending: no grants.
        drv_rst = 1'b1; drv_v = 4'hF; drv_rr = 1'b1;
        cycle();
        cycle();
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        drv_rst = 1'b0; drv_v = 4'b0; drv_rr = 1'b0;
        cycle();

        run_op("single", 2, 30, 40, 54);
        run_op("wrap_zero", 1, 0, 0, 255);
        run_op("wrap_max", 3, 255, 255, 125);
        run_op("small", 0, 8, 1, 7);

        // Round-robin with every requester valid from a fresh reset.
        drv_rst = 1'b1; cycle();
        drv_rst = 1'b0;
        ids_q.delete();
        for (int i = 0; i < N; i++) begin
            xs[i] = $urandom_range(0, 255); ys[i] = $urandom_range(0, 255);
        end
        drv_v = 4'hF; drv_rr = 1'b1;
        repeat (15) cycle();
        chk("rr_count", ids_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ids_q.size()) chk("rr_order", ids_q[i], exp_rr[i]);
        end

        // Backpressure: result must hold while requests keep arriving.
        drv_v = 4'b0010; drv_rr = 1'b0; xs[1] = 100; ys[1] = 20;
        cycle();
        drv_v = 4'hF;
        cycle();
        repeat (5) begin
            cycle();
            chk("bp_data", res_data, 109);
            chk("bp_id", res_id, 1);
            chk("bp_busy", busy, 1);
            chk("bp_ready", obs_ready, 0);
        end
        drv_v = 4'b0; drv_rr = 1'b1;
        cycle();
        drv_rr = 1'b0;

        // Reset during CALC discards the result and restores priority.
        drv_v = 4'b0001; xs[0] = 5; ys[0] = 5;
        cycle();
        drv_v = 4'b0; drv_rst = 1'b1;
        cycle();
        chk("midrst_valid", res_valid, 0);
        chk("midrst_busy", busy, 0);
        drv_rst = 1'b0; drv_v = 4'b0011;
        cycle();
        chk("midrst_pri", obs_ready, 4'b0001);
        drv_v = 4'b0; drv_rr = 1'b1;
        repeat (3) cycle();

        // Random traffic, dropping valids, backpressure and rare resets.
        repeat (400) begin
            drv_rst = ($urandom_range(0, 99) == 0);
            drv_v   = 4'($urandom_range(0, 15));
            drv_rr  = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                xs[i] = $urandom_range(0, 255);
                ys[i] = $urandom_range(0, 255);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
